ycr1_ahb_sim_memory: RTL and testbench

- Simulation-side AHB-Lite slave memory serving the YCR1 core's two AHB master ports: instruction fetch (imem, read-only) and data (dmem, read/write).
- Both ports share one byte-addressed array of 2^YCR1_MEM_POWER_SIZE bytes.
- Provides programmable wait-state injection per port.
- Provides memory-mapped registers that drive the core's external and software interrupt inputs.

---
 rtl/ycr1_ahb_sim_memory.sv | 227 ++++++++++++++++++++++
 tb/tb_ycr1_ahb_sim_memory.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycr1_ahb_sim_memory.sv
// ---------------------------------------------------------------------------
// ycr1_ahb_sim_memory
// Simulation-side AHB-Lite slave memory for the YCR1 core. The instruction
// port (imem, read-only) and the data port (dmem, read/write) share one
// byte-addressed array called mem. Each port has a rotating wait-state
// pattern. A small MMIO window at 0xF000_xxxx drives the interrupt outputs.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ext_irq, soft_irq        registered interrupt requests (MMIO bit0)
//   imem_req_ack_stall_in    imem wait-state pattern (loaded after reset)
//   dmem_req_ack_stall_in    dmem wait-state pattern (loaded after reset)
//   imem_h*                  AHB-Lite instruction fetch slave interface
//   dmem_h*                  AHB-Lite data slave interface
// ---------------------------------------------------------------------------
module ycr1_ahb_sim_memory #(
  parameter int YCR1_MEM_POWER_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ext_irq,
  output logic        soft_irq,
  input  logic [31:0] imem_req_ack_stall_in,
  input  logic [31:0] dmem_req_ack_stall_in,
  input  logic [2:0]  imem_hsize,
  input  logic [1:0]  imem_htrans,
  input  logic [31:0] imem_haddr,
  output logic        imem_hready,
  output logic [31:0] imem_hrdata,
  output logic        imem_hresp,
  input  logic [2:0]  dmem_hsize,
  input  logic [1:0]  dmem_htrans,
  input  logic [31:0] dmem_haddr,
  input  logic        dmem_hwrite,
  input  logic [31:0] dmem_hwdata,
  output logic        dmem_hready,
  output logic [31:0] dmem_hrdata,
  output logic        dmem_hresp
);

  localparam int P = YCR1_MEM_POWER_SIZE;
  localparam int MEM_BYTES = 1 << P;

  localparam logic [15:0] MMIO_PAGE     = 16'hF000;
  localparam logic [15:0] MMIO_EXT_IRQ  = 16'h0100;
  localparam logic [15:0] MMIO_SOFT_IRQ = 16'h0200;

  // Shared backing store; not reset, benches preload it directly.
  logic [7:0] mem [0:MEM_BYTES-1];

  // imem data-phase state
  logic        imem_dphase_q, imem_dphase_d;
  logic [31:0] imem_addr_q,   imem_addr_d;
  logic [2:0]  imem_size_q,   imem_size_d;
  logic [31:0] imem_stall_q,  imem_stall_d;
  logic        imem_load_q,   imem_load_d;

  // dmem data-phase state
  logic        dmem_dphase_q, dmem_dphase_d;
  logic [31:0] dmem_addr_q,   dmem_addr_d;
  logic [2:0]  dmem_size_q,   dmem_size_d;
  logic        dmem_write_q,  dmem_write_d;
  logic [31:0] dmem_stall_q,  dmem_stall_d;
  logic        dmem_load_q,   dmem_load_d;

  // MMIO interrupt registers
  logic        ext_irq_q,  ext_irq_d;
  logic        soft_irq_q, soft_irq_d;

  // Decode helpers
  logic        imem_err, imem_mmio, imem_accept;
  logic [31:0] imem_word;
  logic        dmem_err, dmem_mmio, dmem_accept, dmem_commit, dmem_mem_we;
  logic [31:0] dmem_word, dmem_mmio_rdata;
  logic [3:0]  dmem_be;

  // htrans[0] only separates IDLE/BUSY and NONSEQ/SEQ, which we treat alike.
  logic unused_ok;
  assign unused_ok = ^{imem_htrans[0], dmem_htrans[0]};

  // -------------------------------------------------------------------------
  // imem response: only aligned word fetches are legal; MMIO reads return 0.
  // Errors ignore the stall pattern and complete in one cycle.
  // -------------------------------------------------------------------------
  assign imem_err    = (imem_size_q != 3'd2) || (imem_addr_q[1:0] != 2'b00);
  assign imem_mmio   = (imem_addr_q[31:16] == MMIO_PAGE);
  assign imem_word   = {mem[{imem_addr_q[P-1:2], 2'd3}], mem[{imem_addr_q[P-1:2], 2'd2}],
                        mem[{imem_addr_q[P-1:2], 2'd1}], mem[{imem_addr_q[P-1:2], 2'd0}]};
  assign imem_hready = !imem_dphase_q || imem_err || !imem_stall_q[0];
  assign imem_hresp  = imem_dphase_q && imem_err;
  assign imem_hrdata = (imem_dphase_q && imem_hready && !imem_err && !imem_mmio) ?
                       imem_word : 32'h0;
  assign imem_accept = imem_htrans[1] && imem_hready;

  // -------------------------------------------------------------------------
  // dmem response and write decode.
  // -------------------------------------------------------------------------
  assign dmem_err = (dmem_size_q > 3'd2) ||
                    ((dmem_size_q == 3'd1) && dmem_addr_q[0]) ||
                    ((dmem_size_q == 3'd2) && (dmem_addr_q[1:0] != 2'b00));
  assign dmem_mmio   = (dmem_addr_q[31:16] == MMIO_PAGE);
  assign dmem_word   = {mem[{dmem_addr_q[P-1:2], 2'd3}], mem[{dmem_addr_q[P-1:2], 2'd2}],
                        mem[{dmem_addr_q[P-1:2], 2'd1}], mem[{dmem_addr_q[P-1:2], 2'd0}]};
  assign dmem_hready = !dmem_dphase_q || dmem_err || !dmem_stall_q[0];
  assign dmem_hresp  = dmem_dphase_q && dmem_err;
  assign dmem_accept = dmem_htrans[1] && dmem_hready;
  assign dmem_commit = dmem_dphase_q && dmem_hready && !dmem_err && dmem_write_q;
  assign dmem_mem_we = dmem_commit && !dmem_mmio;

  // MMIO read mux; the console register at offset 0 has no state.
  always_comb begin
    dmem_mmio_rdata = 32'h0;
    case (dmem_addr_q[15:0])
      MMIO_EXT_IRQ:  dmem_mmio_rdata = {31'h0, ext_irq_q};
      MMIO_SOFT_IRQ: dmem_mmio_rdata = {31'h0, soft_irq_q};
      default:       dmem_mmio_rdata = 32'h0;
    endcase
  end

  assign dmem_hrdata = (dmem_dphase_q && dmem_hready && !dmem_err) ?
                       (dmem_mmio ? dmem_mmio_rdata : dmem_word) : 32'h0;

  // Byte enables from size and lane; errored sizes never reach the write.
  always_comb begin
    dmem_be = 4'b1111;
    case (dmem_size_q)
      3'd0:    dmem_be = 4'b0001 << dmem_addr_q[1:0];
      3'd1:    dmem_be = dmem_addr_q[1] ? 4'b1100 : 4'b0011;
      default: dmem_be = 4'b1111;
    endcase
  end

  // -------------------------------------------------------------------------
  // imem next state: the stall pattern loads once after reset and then
  // rotates every clock whether or not a transfer is in flight.
  // -------------------------------------------------------------------------
  always_comb begin
    imem_load_d   = 1'b0;
    imem_stall_d  = imem_load_q ? imem_req_ack_stall_in
                                : {imem_stall_q[0], imem_stall_q[31:1]};
    imem_dphase_d = imem_dphase_q;
    imem_addr_d   = imem_addr_q;
    imem_size_d   = imem_size_q;
    if (imem_accept) begin
      imem_dphase_d = 1'b1;
      imem_addr_d   = imem_haddr;
      imem_size_d   = imem_hsize;
    end else if (imem_hready) begin
      imem_dphase_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // dmem next state, including the MMIO interrupt registers which update on
  // the edge that completes the write.
  // -------------------------------------------------------------------------
  always_comb begin
    dmem_load_d   = 1'b0;
    dmem_stall_d  = dmem_load_q ? dmem_req_ack_stall_in
                                : {dmem_stall_q[0], dmem_stall_q[31:1]};
    dmem_dphase_d = dmem_dphase_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_size_d   = dmem_size_q;
    dmem_write_d  = dmem_write_q;
    ext_irq_d     = ext_irq_q;
    soft_irq_d    = soft_irq_q;
    if (dmem_accept) begin
      dmem_dphase_d = 1'b1;
      dmem_addr_d   = dmem_haddr;
      dmem_size_d   = dmem_hsize;
      dmem_write_d  = dmem_hwrite;
    end else if (dmem_hready) begin
      dmem_dphase_d = 1'b0;
    end
    if (dmem_commit && dmem_mmio) begin
      if (dmem_addr_q[15:0] == MMIO_EXT_IRQ)  ext_irq_d  = dmem_hwdata[0];
      if (dmem_addr_q[15:0] == MMIO_SOFT_IRQ) soft_irq_d = dmem_hwdata[0];
    end
  end

  // Control registers; reset abandons any data phase in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_dphase_q <= 1'b0;
      imem_addr_q   <= 32'h0;
      imem_size_q   <= 3'd0;
      imem_stall_q  <= 32'h0;
      imem_load_q   <= 1'b1;
      dmem_dphase_q <= 1'b0;
      dmem_addr_q   <= 32'h0;
      dmem_size_q   <= 3'd0;
      dmem_write_q  <= 1'b0;
      dmem_stall_q  <= 32'h0;
      dmem_load_q   <= 1'b1;
      ext_irq_q     <= 1'b0;
      soft_irq_q    <= 1'b0;
    end else begin
      imem_dphase_q <= imem_dphase_d;
      imem_addr_q   <= imem_addr_d;
      imem_size_q   <= imem_size_d;
      imem_stall_q  <= imem_stall_d;
      imem_load_q   <= imem_load_d;
      dmem_dphase_q <= dmem_dphase_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_size_q   <= dmem_size_d;
      dmem_write_q  <= dmem_write_d;
      dmem_stall_q  <= dmem_stall_d;
      dmem_load_q   <= dmem_load_d;
      ext_irq_q     <= ext_irq_d;
      soft_irq_q    <= soft_irq_d;
    end
  end

  // Memory write at the end of the dmem data phase. A same-cycle imem read
  // of the same word sees the old contents because its data is combinational.
  always_ff @(posedge clk) begin
    if (dmem_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_be[i]) mem[{dmem_addr_q[P-1:2], 2'(i)}] <= dmem_hwdata[8*i +: 8];
      end
    end
  end

  assign ext_irq  = ext_irq_q;
  assign soft_irq = soft_irq_q;

endmodule

// File: tb/tb_ycr1_ahb_sim_memory.sv
// ---------------------------------------------------------------------------
// tb_ycr1_ahb_sim_memory
// Self-checking bench for ycr1_ahb_sim_memory (1 MiB configuration). A table
// of dmem vectors covers sizes, lanes, errors, aliasing and MMIO; hand-written
// sequences cover reset values, wait states, imem fetches, same-cycle
// imem/dmem collisions, back-to-back read-after-write and reset mid-transfer.
// ---------------------------------------------------------------------------
module tb_ycr1_ahb_sim_memory;

  logic        clk;
  logic        rst_n;
  logic        ext_irq, soft_irq;
  logic [31:0] imem_req_ack_stall_in, dmem_req_ack_stall_in;
  logic [2:0]  imem_hsize;
  logic [1:0]  imem_htrans;
  logic [31:0] imem_haddr;
  logic        imem_hready;
  logic [31:0] imem_hrdata;
  logic        imem_hresp;
  logic [2:0]  dmem_hsize;
  logic [1:0]  dmem_htrans;
  logic [31:0] dmem_haddr;
  logic        dmem_hwrite;
  logic [31:0] dmem_hwdata;
  logic        dmem_hready;
  logic [31:0] dmem_hrdata;
  logic        dmem_hresp;

  int errors = 0;
  int checks = 0;

  ycr1_ahb_sim_memory #(.YCR1_MEM_POWER_SIZE(20)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ext_irq               (ext_irq),
    .soft_irq              (soft_irq),
    .imem_req_ack_stall_in (imem_req_ack_stall_in),
    .dmem_req_ack_stall_in (dmem_req_ack_stall_in),
    .imem_hsize            (imem_hsize),
    .imem_htrans           (imem_htrans),
    .imem_haddr            (imem_haddr),
    .imem_hready           (imem_hready),
    .imem_hrdata           (imem_hrdata),
    .imem_hresp            (imem_hresp),
    .dmem_hsize            (dmem_hsize),
    .dmem_htrans           (dmem_htrans),
    .dmem_haddr            (dmem_haddr),
    .dmem_hwrite           (dmem_hwrite),
    .dmem_hwdata           (dmem_hwdata),
    .dmem_hready           (dmem_hready),
    .dmem_hrdata           (dmem_hrdata),
    .dmem_hresp            (dmem_hresp)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chkData;
    logic [31:0] expData;
    logic        expResp;
    logic        expExt;
    logic        expSoft;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [0:NVEC-1];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } pre_t;

  localparam int NPRE = 6;
  pre_t pre [0:NPRE-1];

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One dmem transfer: address phase, then wait (bounded) for hready
  task automatic applyStimulus(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic resp, output int waits);
    logic done;
    dmem_htrans = 2'b10;
    dmem_hwrite = wr;
    dmem_hsize  = size;
    dmem_haddr  = addr;
    @(posedge clk); #1;
    dmem_htrans = 2'b00;
    dmem_hwdata = wdata;
    waits = 0;
    rdata = 32'h0;
    resp  = 1'b0;
    done  = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (dmem_hready) begin
        rdata = dmem_hrdata;
        resp  = dmem_hresp;
        done  = 1'b1;
      end else begin
        waits++;
      end
    end
    checkOutput("dmem_done_in_time", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  // One imem fetch, same shape as the dmem transfer
  task automatic imemFetch(input logic [2:0] size, input logic [31:0] addr,
                           output logic [31:0] rdata, output logic resp, output int waits);
    logic done;
    imem_htrans = 2'b10;
    imem_hsize  = size;
    imem_haddr  = addr;
    @(posedge clk); #1;
    imem_htrans = 2'b00;
    waits = 0;
    rdata = 32'h0;
    resp  = 1'b0;
    done  = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (imem_hready) begin
        rdata = imem_hrdata;
        resp  = imem_hresp;
        done  = 1'b1;
      end else begin
        waits++;
      end
    end
    checkOutput("imem_done_in_time", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        rsp;
    int          w;

    // Vector table: wr, size, addr, wdata, chkData, expData, expResp, expExt, expSoft
    vecs[0]  = '{1'b1, 3'd0, 32'h0000_0201, 32'h0000_AB00, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'd2, 32'h0000_0200, 32'h0,         1'b1, 32'h0000_AB00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'd1, 32'h0000_0202, 32'hBEEF_0000, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'd2, 32'h0000_0200, 32'h0,         1'b1, 32'hBEEF_AB00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 32'h0000_0203, 32'h0,         1'b1, 32'hBEEF_AB00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'd1, 32'h0000_0202, 32'h0,         1'b1, 32'hBEEF_AB00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd2, 32'h0000_0102, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'd2, 32'h0000_0102, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'd1, 32'h0000_0101, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd3, 32'h0000_0100, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'd2, 32'h0010_0004, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'd2, 32'h0000_0004, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 3'd2, 32'h0010_0004, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 3'd2, 32'hF000_0100, 32'h0000_0001, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 3'd2, 32'hF000_0200, 32'h0000_0001, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 3'd2, 32'hF000_0100, 32'h0,         1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 3'd2, 32'hF000_0200, 32'h0,         1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 3'd2, 32'hF000_0000, 32'h0000_0041, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 3'd2, 32'hF000_0000, 32'h0,         1'b1, 32'h0,         1'b0, 1'b1, 1'b1};
    vecs[20] = '{1'b1, 3'd2, 32'hF000_0300, 32'h0000_0001, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1};
    vecs[21] = '{1'b0, 3'd2, 32'hF000_0300, 32'h0,         1'b1, 32'h0,         1'b0, 1'b1, 1'b1};
    vecs[22] = '{1'b1, 3'd2, 32'hF000_0100, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    vecs[23] = '{1'b1, 3'd2, 32'hF000_0200, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 3'd2, 32'hF000_0200, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 3'd2, 32'hF000_0102, 32'h0000_0001, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};

    pre[0] = '{32'h0000_0100, 32'h1234_5678};
    pre[1] = '{32'h0000_0200, 32'h0000_0000};
    pre[2] = '{32'h0000_0004, 32'h0000_0000};
    pre[3] = '{32'h0000_0300, 32'h1111_1111};
    pre[4] = '{32'h0000_0304, 32'h0000_0000};
    pre[5] = '{32'h0000_0400, 32'h7777_7777};

    rst_n = 1'b0;
    imem_req_ack_stall_in = 32'h0;
    dmem_req_ack_stall_in = 32'h0000_0003;
    imem_hsize  = 3'd2;
    imem_htrans = 2'b00;
    imem_haddr  = 32'h0;
    dmem_hsize  = 3'd2;
    dmem_htrans = 2'b00;
    dmem_haddr  = 32'h0;
    dmem_hwrite = 1'b0;
    dmem_hwdata = 32'h0;

    // Preload the backing store while in reset
    for (int k = 0; k < NPRE; k++) begin
      for (int b = 0; b < 4; b++) begin
        dut.mem[pre[k].addr[19:0] + 20'(b)] <= pre[k].data[8*b +: 8];
      end
    end
    #12;

    // Reset values
    checkOutput("rst_imem_hready", 32'(imem_hready), 32'd1);
    checkOutput("rst_imem_hresp",  32'(imem_hresp),  32'd0);
    checkOutput("rst_imem_hrdata", imem_hrdata,      32'h0);
    checkOutput("rst_dmem_hready", 32'(dmem_hready), 32'd1);
    checkOutput("rst_dmem_hresp",  32'(dmem_hresp),  32'd0);
    checkOutput("rst_dmem_hrdata", dmem_hrdata,      32'h0);
    checkOutput("rst_ext_irq",     32'(ext_irq),     32'd0);
    checkOutput("rst_soft_irq",    32'(soft_irq),    32'd0);

    // Wait states: pattern 0x3 on the first post-reset access gives 2 waits
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd2, 32'h0000_0100, 32'h0, rd, rsp, w);
    checkOutput("stall3_waits", 32'(w),   32'd2);
    checkOutput("stall3_data",  rd,       32'h1234_5678);
    checkOutput("stall3_resp",  32'(rsp), 32'd0);

    // Re-reset with no wait states for the rest of the run
    @(negedge clk);
    rst_n = 1'b0;
    dmem_req_ack_stall_in = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd2, 32'h0000_0100, 32'h0, rd, rsp, w);
    checkOutput("stall0_waits", 32'(w), 32'd0);
    checkOutput("stall0_data",  rd,     32'h1234_5678);

    // imem fetches
    imemFetch(3'd2, 32'h0000_0100, rd, rsp, w);
    checkOutput("imem_word_waits", 32'(w),   32'd0);
    checkOutput("imem_word_data",  rd,       32'h1234_5678);
    checkOutput("imem_word_resp",  32'(rsp), 32'd0);
    imemFetch(3'd0, 32'h0000_0100, rd, rsp, w);
    checkOutput("imem_byte_resp",  32'(rsp), 32'd1);
    checkOutput("imem_byte_waits", 32'(w),   32'd0);
    imemFetch(3'd2, 32'h0000_0102, rd, rsp, w);
    checkOutput("imem_misal_resp", 32'(rsp), 32'd1);

    // Table-driven dmem vectors
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, rsp, w);
      checkOutput($sformatf("vec%0d_resp", i), 32'(rsp), 32'(vecs[i].expResp));
      if (vecs[i].chkData) checkOutput($sformatf("vec%0d_data", i), rd, vecs[i].expData);
      checkOutput($sformatf("vec%0d_ext", i),  32'(ext_irq),  32'(vecs[i].expExt));
      checkOutput($sformatf("vec%0d_soft", i), 32'(soft_irq), 32'(vecs[i].expSoft));
    end

    // imem reads of the MMIO window return 0 even when ext_irq is set
    applyStimulus(1'b1, 3'd2, 32'hF000_0100, 32'h1, rd, rsp, w);
    checkOutput("mmio_ext_set", 32'(ext_irq), 32'd1);
    imemFetch(3'd2, 32'hF000_0100, rd, rsp, w);
    checkOutput("imem_mmio_data", rd,       32'h0);
    checkOutput("imem_mmio_resp", 32'(rsp), 32'd0);
    applyStimulus(1'b1, 3'd2, 32'hF000_0100, 32'h0, rd, rsp, w);
    checkOutput("mmio_ext_clr", 32'(ext_irq), 32'd0);

    // Same-cycle imem read and dmem write to one word: imem sees old data
    imem_htrans = 2'b10; imem_hsize = 3'd2; imem_haddr = 32'h0000_0300;
    dmem_htrans = 2'b10; dmem_hsize = 3'd2; dmem_haddr = 32'h0000_0300; dmem_hwrite = 1'b1;
    @(posedge clk); #1;
    imem_htrans = 2'b00;
    dmem_htrans = 2'b00;
    dmem_hwdata = 32'h2222_2222;
    @(negedge clk);
    checkOutput("collide_imem_hready", 32'(imem_hready), 32'd1);
    checkOutput("collide_imem_data",   imem_hrdata,      32'h1111_1111);
    checkOutput("collide_dmem_hready", 32'(dmem_hready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd2, 32'h0000_0300, 32'h0, rd, rsp, w);
    checkOutput("collide_after", rd, 32'h2222_2222);

    // Back-to-back write then read of the same word
    dmem_htrans = 2'b10; dmem_hsize = 3'd2; dmem_haddr = 32'h0000_0304; dmem_hwrite = 1'b1;
    @(posedge clk); #1;
    dmem_hwdata = 32'h55AA_55AA;
    dmem_hwrite = 1'b0;
    @(negedge clk);
    checkOutput("raw_write_hready", 32'(dmem_hready), 32'd1);
    @(posedge clk); #1;
    dmem_htrans = 2'b00;
    @(negedge clk);
    checkOutput("raw_read_hready", 32'(dmem_hready), 32'd1);
    checkOutput("raw_read_data",   dmem_hrdata,      32'h55AA_55AA);
    @(posedge clk); #1;

    // Reset during a stalled write data phase
    @(negedge clk);
    rst_n = 1'b0;
    dmem_req_ack_stall_in = 32'hFFFF_FFFE;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd2, 32'hF000_0100, 32'h1, rd, rsp, w);
    checkOutput("midrst_pre_waits", 32'(w),       32'd0);
    checkOutput("midrst_pre_ext",   32'(ext_irq), 32'd1);
    dmem_htrans = 2'b10; dmem_hsize = 3'd2; dmem_haddr = 32'h0000_0400; dmem_hwrite = 1'b1;
    @(posedge clk); #1;
    dmem_htrans = 2'b00;
    dmem_hwdata = 32'h9999_9999;
    repeat (3) @(negedge clk);
    checkOutput("midrst_stalled", 32'(dmem_hready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_hready", 32'(dmem_hready), 32'd1);
    checkOutput("midrst_hresp",  32'(dmem_hresp),  32'd0);
    checkOutput("midrst_ext",    32'(ext_irq),     32'd0);
    checkOutput("midrst_soft",   32'(soft_irq),    32'd0);
    dmem_req_ack_stall_in = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd2, 32'h0000_0400, 32'h0, rd, rsp, w);
    checkOutput("midrst_word_kept", rd, 32'h7777_7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
